// File: rtl/riscv_defs.sv
// Shared definitions for the instruction fetch slice: data width, opcodes,
// fetch FSM encoding and the {pc, word} buffer entry.
package riscv_defs;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] word;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fila_instrucao.sv
// Two-entry FIFO holding fetched {pc, word} pairs; flush empties it in one cycle.
module fila_instrucao #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_out,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_pop;
   logic         do_push;

   assign full     = (count == 2'd2);
   assign empty    = (count == 2'd0);
   assign data_out = mem[rd_ptr];

   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: one outstanding memory request, 2-deep {pc, word} buffer,
// branch redirect with discard of in-flight responses.
module busca_instrucao
   import riscv_defs::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [6:0]  opcode,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   fetch_state_t    state;
   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] req_pc;
   fetch_entry_t    head;
   fetch_entry_t    wr_entry;
   logic [1:0]      count;
   logic            full;
   logic            empty;
   logic            outstanding;
   logic            slot_free;
   logic            push;
   logic            pop;
   logic [2:0]      credit;

   assign outstanding = (state == ST_WAIT);
   assign pop         = instr_valid && instr_ready && !redirect;
   assign push        = outstanding && imem_rvalid && !redirect && (!full || pop);
   assign wr_entry    = '{pc: req_pc, word: imem_rdata};

   // Occupancy after this edge plus the request we might issue must stay <= 2;
   // a response landing now just moves from "outstanding" into the buffer.
   assign slot_free = (state == ST_IDLE) || (outstanding && imem_rvalid);
   assign credit    = {1'b0, count} + {2'b00, outstanding} - {2'b00, pop};
   assign imem_req  = !reset && !redirect && slot_free && (credit < 3'd2);
   assign imem_addr = fpc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         fpc    <= RESET_PC;
         req_pc <= '0;
      end else if (redirect) begin
         fpc <= word_align(redirect_pc);
         // A response still owed by memory must be swallowed before refetching.
         if ((state != ST_IDLE) && !imem_rvalid) state <= ST_DROP;
         else                                    state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (imem_req) state <= ST_WAIT;
            ST_WAIT: if (imem_rvalid) state <= imem_req ? ST_WAIT : ST_IDLE;
            ST_DROP: if (imem_rvalid) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (imem_req) begin
            fpc    <= fpc + 32'd4;
            req_pc <= fpc;
         end
      end
   end

   fila_instrucao #(.W(2 * XLEN)) u_fila (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .flush    (redirect),
      .data_in  (wr_entry),
      .data_out (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   assign instr_valid = !empty;
   assign instr       = head.word;
   assign instr_pc    = head.pc;
   assign opcode      = head.word[6:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// Randomized bench for busca_instrucao: memory with variable latency and a
// queue-based scoreboard of the expected instruction stream.
module tb_busca_instrucao;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   always #5 clk = ~clk;

   busca_instrucao #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
   endfunction

   // memory side, driven by what the DUT actually does
   logic        mem_busy = 1'b0;
   int          mem_due  = 0;
   logic [31:0] mem_addr = '0;
   int          cyc      = 0;

   // reference: expected buffer contents, fetch pointer, owed responses
   logic [63:0] q[$];
   logic [31:0] m_fpc  = RPC;
   logic        m_wait = 1'b0;
   logic        m_drop = 1'b0;

   int          lat_min = 1, lat_max = 1, rdy_pct = 100, redir_pct = 0;
   logic        force_redir = 1'b0;
   logic        redir_on_rv = 1'b0;
   logic [31:0] force_pc = '0;
   logic        chk_rst_out = 1'b0;

   task automatic cycle(input logic rst);
      logic        rv, pop, exp_req;
      logic [31:0] rpc;
      @(posedge clk);
      #1;
      cyc++;
      rv          = mem_busy && (cyc == mem_due);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
      reset       = rst;
      rpc         = $urandom;
      redirect    = 1'b0;
      if (!rst) begin
         if (force_redir) begin
            redirect = 1'b1; rpc = force_pc; force_redir = 1'b0;
         end else if (redir_on_rv && rv && q.size() == 1) begin
            redirect = 1'b1; rpc = force_pc; redir_on_rv = 1'b0;
         end else if ($urandom_range(99) < redir_pct) begin
            redirect = 1'b1;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(15);
         end
      end
      redirect_pc = rpc;
      instr_ready = !redirect && ($urandom_range(99) < rdy_pct);
      #3;
      if (rst) begin
         chk("req_in_reset", imem_req, 0);
         q.delete();
         m_fpc  = RPC;
         m_wait = 1'b0;
         m_drop = 1'b0;
      end else begin
         if (chk_rst_out) begin
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_opcode", opcode, 0);
            chk_rst_out = 1'b0;
         end
         pop     = instr_ready && (q.size() > 0);
         exp_req = !redirect && !m_drop && (!m_wait || rv)
                   && (q.size() + int'(m_wait) - int'(pop) < 2);
         chk("imem_req", imem_req, exp_req);
         if (exp_req && imem_req) chk("imem_addr", imem_addr, m_fpc);
         chk("instr_valid", instr_valid, q.size() > 0);
         if (q.size() > 0) begin
            chk("instr_pc", instr_pc, q[0][63:32]);
            chk("instr", instr, q[0][31:0]);
            chk("opcode", opcode, 32'(q[0][6:0]));
         end
         if (redirect) begin
            q.delete();
            m_fpc  = {rpc[31:2], 2'b00};
            m_drop = (m_wait || m_drop) && !rv;
            m_wait = 1'b0;
         end else begin
            if (pop) void'(q.pop_front());
            if (m_wait && rv) q.push_back({mem_addr, imem_rdata});
            if (m_drop && rv) m_drop = 1'b0;
            m_wait = (m_wait && !rv) || exp_req;
            if (exp_req) m_fpc = m_fpc + 32'd4;
         end
      end
      if (rv) mem_busy = 1'b0;
      if (imem_req) begin
         chk("one_outstanding", mem_busy, 0);
         mem_busy = 1'b1;
         mem_due  = cyc + $urandom_range(lat_max, lat_min);
         mem_addr = imem_addr;
      end
   endtask

   task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int rdr);
      lat_min = lmin; lat_max = lmax; rdy_pct = rdy; redir_pct = rdr;
   endtask

   initial begin
      // reset and the 1-cycle-memory streaming case
      set_knobs(1, 1, 100, 0);
      cycle(1'b1);
      cycle(1'b1);
      chk_rst_out = 1'b1;
      repeat (10) cycle(1'b0);

      // decode stalled: two fetches then hold
      set_knobs(1, 1, 0, 0);
      repeat (10) cycle(1'b0);
      set_knobs(1, 1, 100, 0);
      repeat (5) cycle(1'b0);

      // slow memory
      set_knobs(3, 3, 100, 0);
      repeat (15) cycle(1'b0);

      // redirect to 0x40 while a 3-cycle request is in flight
      for (int i = 0; i < 10 && !(mem_busy && mem_due > cyc + 1); i++) cycle(1'b0);
      chk("inflight_reached", mem_busy, 1);
      force_pc = 32'h40; force_redir = 1'b1;
      repeat (12) cycle(1'b0);

      // redirect on the same cycle a response would fill the buffer
      set_knobs(2, 2, 0, 0);
      force_pc = 32'h43; redir_on_rv = 1'b1;
      for (int i = 0; i < 20 && redir_on_rv; i++) cycle(1'b0);
      chk("redir_on_rv_hit", redir_on_rv, 0);
      repeat (4) cycle(1'b0);
      set_knobs(2, 2, 100, 0);
      repeat (8) cycle(1'b0);

      // reset during an outstanding request; stale response arrives in reset
      set_knobs(3, 3, 100, 0);
      for (int i = 0; i < 10 && !(mem_busy && mem_due > cyc + 1); i++) cycle(1'b0);
      chk("wait_reached", mem_busy, 1);
      for (int i = 0; i < 6 && mem_busy; i++) cycle(1'b1);
      chk("stale_drained", mem_busy, 0);
      repeat (10) cycle(1'b0);

      // random traffic, including wrap-around targets
      set_knobs(1, 3, 60, 5);
      repeat (800) cycle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
